// File: rtl/load_store_unit.sv
// Memory stage: issues one load/store at a time to a req/ack port and registers the writeback.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being silently aligned.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  rd_address_in,
  input  logic [31:0] pc_plus_four_in,
  input  logic        data_write_en_in,
  input  logic        reg_write_in,
  input  logic [1:0]  alu_or_load_or_pc_plus_four_in,
  input  logic [1:0]  data_men_write_command_in,
  input  logic [2:0]  load_gen_command_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misaligned_fault
`endif
);

  typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

  state_t      state_r;
  logic [2:0]  ld_cmd_r;
  logic [1:0]  ld_off_r;
  logic [4:0]  ld_rd_r;
  logic        ld_wb_r;

  logic        is_store_s;
  logic        is_load_s;
  logic        mem_op_s;
  logic        fault_s;
  logic [1:0]  off_s;

  function automatic logic [3:0] store_strobe(input logic [1:0] cmd, input logic [1:0] off);
    logic [3:0] s;
    case (cmd)
      2'b00:   s = 4'b0001 << off;
      2'b01:   s = 4'b0011 << {off[1], 1'b0};
      2'b10:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] cmd, input logic [31:0] d);
    logic [31:0] r;
    case (cmd)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] cmd, input logic [1:0] off,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (cmd)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic store, input logic [1:0] scmd,
                                      input logic [2:0] lcmd, input logic [1:0] off);
    logic m;
    if (store) begin
      case (scmd)
        2'b01:   m = off[0];
        2'b10:   m = (off != 2'b00);
        default: m = 1'b0;
      endcase
    end else begin
      case (lcmd)
        3'b000, 3'b100: m = 1'b0;
        3'b001, 3'b101: m = off[0];
        default:        m = (off != 2'b00);
      endcase
    end
    return m;
  endfunction
`endif

  assign off_s      = alu_result_in[1:0];
  // A store flagged as a load too is treated purely as a store.
  assign is_store_s = data_write_en_in && (data_men_write_command_in != 2'b11);
  assign is_load_s  = reg_write_in && (alu_or_load_or_pc_plus_four_in == 2'b01) && !is_store_s;
  assign mem_op_s   = is_store_s || is_load_s;

`ifdef LSU_MISALIGN_TRAP_EN
  assign fault_s = mem_op_s &&
                   misaligned(is_store_s, data_men_write_command_in, load_gen_command_in, off_s);
`else
  assign fault_s = 1'b0;
`endif

  assign stall = !reset && (((state_r == ST_IDLE) && mem_op_s && !fault_s) ||
                            ((state_r == ST_REQ) && !mem_ack));

  // Request FSM, memory port registers and registered writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_wstrb <= 4'b0000;
      wb_en     <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'h0000_0000;
      ld_cmd_r  <= 3'b000;
      ld_off_r  <= 2'b00;
      ld_rd_r   <= 5'd0;
      ld_wb_r   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_fault <= 1'b0;
`endif
    end else begin
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_fault <= (state_r == ST_IDLE) && fault_s;
`endif
      case (state_r)
        ST_IDLE: begin
          if (mem_op_s && !fault_s) begin
            state_r   <= ST_REQ;
            mem_req   <= 1'b1;
            mem_we    <= is_store_s;
            mem_addr  <= {alu_result_in[31:2], 2'b00};
            mem_wstrb <= is_store_s ? store_strobe(data_men_write_command_in, off_s) : 4'b0000;
            mem_wdata <= is_store_s ? store_data(data_men_write_command_in, write_data_in)
                                    : 32'h0000_0000;
            ld_cmd_r  <= load_gen_command_in;
            ld_off_r  <= off_s;
            ld_rd_r   <= rd_address_in;
            ld_wb_r   <= is_load_s && (rd_address_in != 5'd0);
            wb_en     <= 1'b0;
          end else begin
            wb_en <= reg_write_in && !is_store_s && !fault_s && (rd_address_in != 5'd0);
            wb_rd <= rd_address_in;
            wb_data <= (alu_or_load_or_pc_plus_four_in == 2'b10) ? pc_plus_four_in
                                                                 : alu_result_in;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_r   <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            wb_en     <= ld_wb_r;
            wb_rd     <= ld_rd_r;
            wb_data   <= load_extract(ld_cmd_r, ld_off_r, mem_rdata);
          end else begin
            wb_en <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mem_req <= 1'b0;
          wb_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule
